// File: rtl/crc_receiver.sv
// Two-stage CRC syndrome checker with single-bit correction and saturating
// codeword/error statistics. Codeword layout is {data, crc}, data in the MSBs.
module crc_receiver #(
  parameter int              BW         = 4,
  parameter int              CRC_BW     = 3,
  parameter logic [CRC_BW:0] POLY       = 4'b1011,
  parameter int              CNT_W      = 16,
  parameter bit              CORRECT_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  input  logic [BW+CRC_BW-1:0]   in,
  input  logic                   clr_cnt,
  output logic                   out_valid,
  output logic [BW-1:0]          out,
  output logic                   err_flag,
  output logic                   corr_flag,
  output logic                   uncorr_flag,
  output logic [CNT_W-1:0]       cw_cnt,
  output logic [CNT_W-1:0]       err_cnt
);
  localparam int N = BW + CRC_BW;

  // Polynomial remainder of v mod POLY by bitwise long division, MSB first.
  function automatic logic [CRC_BW-1:0] f_mod(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = v;
    for (int i = N - 1; i >= CRC_BW; i--)
      if (r[i]) r[i -: CRC_BW+1] = r[i -: CRC_BW+1] ^ POLY;
    return r[CRC_BW-1:0];
  endfunction

  logic [CRC_BW-1:0] w_syn;
  logic [N-1:0]      r_cw;
  logic [CRC_BW-1:0] r_syn;
  logic              r_vld1;
  logic [N-1:0]      w_match;
  logic [N-1:0]      w_fix;
  logic              w_err, w_one, w_corr, w_uncorr;

  assign w_syn = f_mod(in);

  // Syndrome of a lone error at bit g is x^g mod POLY; fixed at elaboration.
  for (genvar g = 0; g < N; g++) begin : g_pat
    localparam logic [N-1:0]      ONE_HOT = {{(N-1){1'b0}}, 1'b1} << g;
    localparam logic [CRC_BW-1:0] PAT     = f_mod(ONE_HOT);
    assign w_match[g] = (r_syn == PAT);
  end

  assign w_err    = |r_syn;
  assign w_one    = $onehot(w_match);
  assign w_corr   = w_err && CORRECT_EN && w_one;
  assign w_uncorr = w_err && !w_one;
  assign w_fix    = w_corr ? (r_cw ^ w_match) : r_cw;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cw        <= '0;
      r_syn       <= '0;
      r_vld1      <= 1'b0;
      out_valid   <= 1'b0;
      out         <= '0;
      err_flag    <= 1'b0;
      corr_flag   <= 1'b0;
      uncorr_flag <= 1'b0;
      cw_cnt      <= '0;
      err_cnt     <= '0;
    end else begin
      r_vld1    <= in_valid;
      out_valid <= r_vld1;
      if (in_valid) begin
        r_cw  <= in;
        r_syn <= w_syn;
      end
      if (r_vld1) begin
        out         <= w_fix[N-1:CRC_BW];
        err_flag    <= w_err;
        corr_flag   <= w_corr;
        uncorr_flag <= w_uncorr;
      end
      // Clear wins over a same-edge increment; that word goes uncounted.
      if (clr_cnt) begin
        cw_cnt  <= '0;
        err_cnt <= '0;
      end else if (in_valid) begin
        if (cw_cnt != '1) cw_cnt <= cw_cnt + CNT_W'(1);
        if ((w_syn != '0) && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_crc_receiver.sv
// Scoreboard bench for crc_receiver: a correcting instance (default params) and
// a detect-only instance with 2-bit counters run side by side on one stream.
module tb_crc_receiver;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in_valid = 1'b0;
  logic [6:0] in = '0;
  logic       clr_cnt = 1'b0;

  logic       a_ov, a_e, a_c, a_u;
  logic [3:0] a_out;
  logic [15:0] a_cw, a_ec;
  logic       b_ov, b_e, b_c, b_u;
  logic [3:0] b_out;
  logic [1:0] b_cw, b_ec;

  typedef struct packed {logic [3:0] d; logic e; logic c; logic u;} exp_t;
  exp_t qa[$];
  exp_t qb[$];
  int n_chk = 0;
  int n_err = 0;
  logic v1 = 1'b0, v2 = 1'b0;

  crc_receiver dut_a (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in(in), .clr_cnt(clr_cnt),
    .out_valid(a_ov), .out(a_out), .err_flag(a_e), .corr_flag(a_c),
    .uncorr_flag(a_u), .cw_cnt(a_cw), .err_cnt(a_ec));

  crc_receiver #(.CNT_W(2), .CORRECT_EN(1'b0)) dut_b (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in(in), .clr_cnt(clr_cnt),
    .out_valid(b_ov), .out(b_out), .err_flag(b_e), .corr_flag(b_c),
    .uncorr_flag(b_u), .cw_cnt(b_cw), .err_cnt(b_ec));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter model: serial LFSR form of x^3+x+1.
  function automatic logic [2:0] enc(input logic [3:0] d);
    logic [2:0] r;
    logic fb;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      fb = d[i] ^ r[2];
      r  = {r[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
    end
    return r;
  endfunction

  task automatic send(input logic [6:0] cw, input exp_t ea, input exp_t eb);
    @(negedge clk);
    in_valid = 1'b1;
    in = cw;
    qa.push_back(ea);
    qb.push_back(eb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      clr_cnt = 1'b0;
    end
  endtask

  task automatic chk_cnt(input string tag, input int acw, input int aec,
                         input int bcw, input int bec);
    chk({tag, "_a_cw"}, 32'(a_cw), 32'(acw));
    chk({tag, "_a_ec"}, 32'(a_ec), 32'(aec));
    chk({tag, "_b_cw"}, 32'(b_cw), 32'(bcw));
    chk({tag, "_b_ec"}, 32'(b_ec), 32'(bec));
  endtask

  // Monitor: expected out_valid from an independent 2-deep valid model, data from queues.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rstn) begin
        v1 = 1'b0; v2 = 1'b0;
      end else begin
        v2 = v1; v1 = in_valid;
      end
      #1;
      chk("a_out_valid", 32'(a_ov), 32'(v2));
      chk("b_out_valid", 32'(b_ov), 32'(v2));
      if (a_ov) begin
        if (qa.size() == 0) chk("a_unexpected_out", 32'(1), 32'(0));
        else begin
          e = qa.pop_front();
          chk("a_data", 32'(a_out), 32'(e.d));
          chk("a_flags", 32'({a_e, a_c, a_u}), 32'({e.e, e.c, e.u}));
        end
      end
      if (b_ov) begin
        if (qb.size() == 0) chk("b_unexpected_out", 32'(1), 32'(0));
        else begin
          e = qb.pop_front();
          chk("b_data", 32'(b_out), 32'(e.d));
          chk("b_flags", 32'({b_e, b_c, b_u}), 32'({e.e, e.c, e.u}));
        end
      end
    end
  end

  initial begin
    logic [6:0] cw;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ov", 32'({a_ov, b_ov}), 32'(0));
    chk("rst_out", 32'({a_out, a_e, a_c, a_u}), 32'(0));
    chk_cnt("rst", 0, 0, 0, 0);
    rstn = 1'b1;

    // Clean stream
    send(7'h00, '{4'h0, 1'b0, 1'b0, 1'b0}, '{4'h0, 1'b0, 1'b0, 1'b0});
    send(7'h0B, '{4'h1, 1'b0, 1'b0, 1'b0}, '{4'h1, 1'b0, 1'b0, 1'b0});
    send(7'h53, '{4'hA, 1'b0, 1'b0, 1'b0}, '{4'hA, 1'b0, 1'b0, 1'b0});
    idle(2);
    chk_cnt("clean", 3, 0, 3, 0);

    // Data-bit error, CRC-bit error, double error (miscorrected by design)
    send(7'h5B, '{4'hA, 1'b1, 1'b1, 1'b0}, '{4'hB, 1'b1, 1'b0, 1'b0});
    idle(1);
    chk_cnt("single", 4, 1, 3, 1);
    send(7'h52, '{4'hA, 1'b1, 1'b1, 1'b0}, '{4'hA, 1'b1, 1'b0, 1'b0});
    send(7'h50, '{4'hB, 1'b1, 1'b1, 1'b0}, '{4'hA, 1'b1, 1'b0, 1'b0});
    idle(2);
    chk_cnt("double", 6, 3, 3, 3);

    // Bubbles, then clear colliding with a valid word
    send(7'h0B, '{4'h1, 1'b0, 1'b0, 1'b0}, '{4'h1, 1'b0, 1'b0, 1'b0});
    idle(1);
    send(7'h53, '{4'hA, 1'b0, 1'b0, 1'b0}, '{4'hA, 1'b0, 1'b0, 1'b0});
    send(7'h0B, '{4'h1, 1'b0, 1'b0, 1'b0}, '{4'h1, 1'b0, 1'b0, 1'b0});
    clr_cnt = 1'b1;
    idle(1);
    chk_cnt("clr", 0, 0, 0, 0);
    send(7'h5B, '{4'hA, 1'b1, 1'b1, 1'b0}, '{4'hB, 1'b1, 1'b0, 1'b0});
    idle(2);
    chk_cnt("after_clr", 1, 1, 1, 1);

    // Async reset mid-stream
    send(7'h53, '{4'hA, 1'b0, 1'b0, 1'b0}, '{4'hA, 1'b0, 1'b0, 1'b0});
    send(7'h5B, '{4'hA, 1'b1, 1'b1, 1'b0}, '{4'hB, 1'b1, 1'b0, 1'b0});
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_ov", 32'({a_ov, b_ov}), 32'(0));
    chk("arst_a_out", 32'({a_out, a_e, a_c, a_u}), 32'(0));
    chk("arst_b_out", 32'({b_out, b_e, b_c, b_u}), 32'(0));
    chk_cnt("arst", 0, 0, 0, 0);
    qa.delete();
    qb.delete();
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    send(7'h0B, '{4'h1, 1'b0, 1'b0, 1'b0}, '{4'h1, 1'b0, 1'b0, 1'b0});
    idle(3);
    chk_cnt("post_rst", 1, 0, 1, 0);

    // Full single-bit sweep
    clr_cnt = 1'b1;
    idle(1);
    for (int d = 0; d < 16; d++)
      for (int b = 0; b < 7; b++) begin
        cw = {4'(d), enc(4'(d))} ^ (7'h01 << b);
        send(cw, '{4'(d), 1'b1, 1'b1, 1'b0}, '{cw[6:3], 1'b1, 1'b0, 1'b0});
      end
    idle(3);
    chk_cnt("sweep", 112, 112, 3, 3);
    chk("queues_drained", 32'(qa.size() + qb.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/crc_receiver.md
Name: crc_receiver

Overview:
- Downstream stage of the CRC transmitter: accepts one systematic codeword per clock ({data, crc}, data in MSBs) and recomputes the syndrome against generator POLY.
- Corrects single-bit errors using the cyclic Hamming property of the default CRC-3 code, then outputs recovered data with status flags.
- Keeps saturating statistics counters for received and erroneous codewords.

Parameters:
- BW, 4, data width.
- CRC_BW, 3, CRC width.
- POLY, 4'b1011, generator polynomial, CRC_BW+1 bits, MSB = x^CRC_BW (g = x^3+x+1).
- CNT_W, 16, statistics counter width.
- CORRECT_EN, 1, 1 = apply single-bit correction; 0 = detect only.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  codeword qualifier.
- in  in  BW+CRC_BW  received codeword.
- clr_cnt  in  1  synchronous clear of statistics counters.
- out_valid  out  1  output qualifier.
- out  out  BW  recovered (corrected if enabled) data.
- err_flag  out  1  syndrome was nonzero for this word.
- corr_flag  out  1  a bit was flipped by the corrector.
- uncorr_flag  out  1  nonzero syndrome with no unique single-bit match.
- cw_cnt  out  CNT_W  valid codewords received.
- err_cnt  out  CNT_W  codewords with nonzero syndrome.

Behaviour:
- Reset: async assert clears all pipeline registers, all outputs and both counters to 0. No output activity until the first in_valid after rstn deasserts.
- Reset mid-operation discards in-flight words; out_valid is 0 on the first edge after release.
- Pipeline has 2 stages, no stall; in_valid is accepted every cycle.
  - S1 registers the codeword and its syndrome: remainder of codeword (as polynomial, MSB = x^(BW+CRC_BW-1)) mod POLY, computed by bitwise long division over BW+CRC_BW steps.
  - S2 registers out, flags and out_valid.
- Latency: word presented with in_valid at edge k appears with out_valid=1 at edge k+2.
- Bubble behaviour: in_valid=0 produces out_valid=0 two cycles later. out and flags hold their last values while out_valid=0.
- Correction table: for i in 0..BW+CRC_BW-1, pattern_i = x^i mod POLY, built at elaboration.
  - Syndrome 0: err_flag=0, corr_flag=0, uncorr_flag=0; out = codeword[BW+CRC_BW-1:CRC_BW].
  - Syndrome nonzero and exactly one i matches with CORRECT_EN=1: flip bit i; err_flag=1, corr_flag=1. If i < CRC_BW, data is unchanged but corr_flag is still 1.
  - Syndrome nonzero, zero or multiple matches, or CORRECT_EN=0: uncorrectable. err_flag=1, uncorr_flag=1 only for the no/multiple-match case, corr_flag=0; out = raw data bits.
  - With the default parameters every nonzero syndrome matches exactly one position. Double errors are therefore miscorrected; this is a code limit, not a bug.
- Counters, updated at the S1 register edge for each valid word:
  - cw_cnt += 1.
  - err_cnt += 1 when the syndrome is nonzero.
  - Both saturate at all-ones and do not wrap.
- clr_cnt=1 at an edge sets both counters to 0. Clear takes priority over a same-cycle increment; that word is not counted.
- Flags are only meaningful while out_valid=1.

Test Plan:
- Reset then clean stream: in 7'h00, 7'h0B, 7'h53 on consecutive cycles -> out 0x0, 0x1, 0xA at edges +2, +3, +4; all flags 0; cw_cnt=3, err_cnt=0.
- Single data-bit error: in 7'h5B (7'h53 ^ bit3) -> syndrome 3'b011, out 0xA, err_flag=1, corr_flag=1, err_cnt=1.
- Single CRC-bit error: in 7'h52 -> syndrome 3'b001, out 0xA, corr_flag=1. Same input with CORRECT_EN=0 -> out 0xA, corr_flag=0, err_flag=1.
- Double error: in 7'h50 (bits 0,1 flipped) -> syndrome 3'b011, miscorrected to out 0xB, corr_flag=1. Confirms the documented limit.
- Bubbles and clear: pattern valid/invalid/valid gives out_valid 1/0/1 with 2-cycle latency. clr_cnt asserted in the same cycle as a valid word -> cw_cnt=0 afterwards. Preloading a counter to all-ones and sending a word -> counter stays all-ones.
- Async reset mid-stream: pull rstn low between clock edges -> out_valid, out, flags and counters go to 0 immediately. First output after release comes from a word sent after release.
- Full sweep: all 16 data values encoded by the transmitter model, each with every one of the 7 single-bit flips (112 words) -> 0 data mismatches; err_cnt=112.
